// File: rtl/cpu_defs.sv
// Shared CPU definitions: multiply/divide op encodings and the
// mult_div control FSM state encodings. The instruction decoder drives
// op using the same constants.
package cpu_defs;

    // op encodings. Bit 1 selects divide and bit 0 selects unsigned.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // mult_div FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_abs.sv
// md_abs: combinational two's-complement magnitude/sign extractor.
//   val       : operand
//   is_signed : treat val as signed. When this is low, val passes through.
//   mag       : |val| as an unsigned number (the most negative value maps
//               to itself, which is also correct as unsigned)
//   neg       : operand is negative
module md_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             neg
);

    assign neg = is_signed & val[WIDTH-1];
    assign mag = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/mult_div.sv
// mult_div: iterative HI/LO multiply/divide unit.
// This unit computes one bit per cycle over operand magnitudes. Multiply
// uses shift-add and divide uses restoring division. A FIX cycle then
// applies the sign corrections and loads HI and LO.
//   clk, rst       : clock and synchronous active-high reset
//   a, b, op       : operands and operation, latched when start is accepted
//   start          : begin an operation (ignored while busy)
//   we_hi, we_lo   : MTHI/MTLO write enables for wdata (ignored while busy)
//   busy           : high in CALC and FIX
//   done           : one-cycle pulse in DONE
//   hi, lo         : HI/LO registers
module mult_div
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_lat;
    logic [WIDTH-1:0] a_lat;
    logic             neg_a, neg_b;
    // The multiplicand (for multiply) or the divisor (for divide).
    logic [WIDTH-1:0] op_mag;
    // Multiply: {acc_hi, acc_lo} is the partial product. acc_lo is
    // preloaded with the multiplier and shifted out as it is consumed.
    // Divide: acc_hi is the partial remainder and acc_lo is the
    // dividend/quotient shift register.
    logic [WIDTH-1:0] acc_hi, acc_lo;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;
    logic             accept;

    md_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val(a), .is_signed(op_is_signed(op)), .mag(a_mag), .neg(a_neg)
    );
    md_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val(b), .is_signed(op_is_signed(op)), .mag(b_mag), .neg(b_neg)
    );

    assign accept = start & ~busy;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_CALC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_CALC) || (state == ST_FIX);
        done = (state == ST_DONE);
    end

    // ---------------- iteration step ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_mag} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, op_mag};
        div_ge    = (div_shift >= {1'b0, op_mag});
        if (op_is_div(op_lat)) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            // The carry out of the add becomes the new top bit. The low
            // bit of the sum moves into the top of the multiplier register.
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod = {acc_hi, acc_lo};
        if (op_is_signed(op_lat) && (neg_a ^ neg_b)) prod = ~prod + (2*WIDTH)'(1);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_is_div(op_lat)) begin
            if (op_mag == '0) begin
                res_lo = '1;
                res_hi = a_lat;
            end else begin
                // The quotient is negative when the signs differ. The
                // remainder follows the sign of the dividend. The most
                // negative value divided by -1 wraps back to itself.
                res_lo = (neg_a ^ neg_b) ? (~acc_lo + WIDTH'(1)) : acc_lo;
                res_hi = neg_a ? (~acc_hi + WIDTH'(1)) : acc_hi;
            end
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_lat <= '0;
            a_lat  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            op_mag <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (accept) begin
                op_lat <= op;
                a_lat  <= a;
                neg_a  <= a_neg;
                neg_b  <= b_neg;
                op_mag <= op_is_div(op) ? b_mag : a_mag;
                acc_hi <= '0;
                acc_lo <= op_is_div(op) ? a_mag : b_mag;
                cnt    <= '0;
            end else if (state == ST_CALC) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + CW'(1);
            end
            if (state == ST_FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (!busy && we_hi) hi <= wdata;
            if (!busy && we_lo) lo <= wdata;
        end
    end

endmodule
